// File: rtl/hamming_thresh_nbit_ncc_pkg.sv
// hamming_pkg: shared types and width helpers for the Hamming-distance engines.
//   state_t    - FSM states (IDLE, ACC)
//   clog2()    - ceiling log2
//   pc_width() - popcount output width for an m-bit chunk, clog2(m)+1
package hamming_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    return $clog2(v);
  endfunction

  function automatic int pc_width(input int m);
    return clog2(m) + 1;
  endfunction

endpackage

// File: rtl/hamming_thresh_nbit_ncc_if.sv
// hamming_thresh_nbit_ncc_if: streaming chunk/result bundle for the engine.
//   start, g_input, e_input : driven by the source (master)
//   o, match, done, busy    : driven by the engine (slave)
// N and CC must match the engine instance; M and OW are derived.
interface hamming_thresh_nbit_ncc_if
  import hamming_pkg::*;
#(
  parameter int N  = 32,
  parameter int CC = 8
);
  localparam int M  = N / CC;
  localparam int OW = clog2(N) + 1;

  logic          start;
  logic [M-1:0]  g_input;
  logic [M-1:0]  e_input;
  logic [OW-1:0] o;
  logic          match;
  logic          done;
  logic          busy;

  modport master (
    output start, g_input, e_input,
    input  o, match, done, busy
  );

  modport slave (
    input  start, g_input, e_input,
    output o, match, done, busy
  );
endinterface

// File: rtl/hamming_thresh_nbit_ncc_popcount_mbit.sv
// popcount_mbit: combinational population count as a balanced adder tree.
//   in_bits : M-bit input
//   count   : number of set bits, pc_width(M) bits wide
// The input is padded with zeros up to the next power of two; each tree
// level lives in its own packed vector so no signal feeds back on itself.
module popcount_mbit
  import hamming_pkg::*;
#(
  parameter  int M = 4,
  localparam int W = pc_width(M)
) (
  input  logic [M-1:0] in_bits,
  output logic [W-1:0] count
);
  localparam int L = clog2(M);
  localparam int P = 1 << L;

  genvar gi, gj;
  generate
    for (gi = 0; gi <= L; gi++) begin : g_lvl
      logic [(P >> gi)*W-1:0] s;
      for (gj = 0; gj < (P >> gi); gj++) begin : g_node
        if (gi == 0) begin : g_leaf
          if (gj < M) begin : g_bit
            assign s[gj*W +: W] = W'(in_bits[gj]);
          end else begin : g_pad
            assign s[gj*W +: W] = '0;
          end
        end else begin : g_add
          assign s[gj*W +: W] = g_lvl[gi-1].s[(2*gj)*W +: W]
                              + g_lvl[gi-1].s[(2*gj+1)*W +: W];
        end
      end
    end
  endgenerate

  assign count = g_lvl[L].s[W-1:0];
endmodule

// File: rtl/hamming_thresh_nbit_ncc.sv
// hamming_thresh_nbit_ncc: sequential Hamming-distance engine with threshold.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : hamming_thresh_nbit_ncc_if.slave
//         start/g_input/e_input in; o/match/done/busy out (all registered)
// Two N-bit vectors arrive LSB chunk first, M = N/CC bits per cycle; chunk 0
// comes with start. done pulses once the full distance is in o, and match
// reports distance <= THR. A new start is accepted in the done cycle.
module hamming_thresh_nbit_ncc
  import hamming_pkg::*;
#(
  parameter int N   = 32,
  parameter int CC  = 8,
  parameter int THR = N / 4
) (
  input  logic                     clk,
  input  logic                     rst,
  hamming_thresh_nbit_ncc_if.slave bus
);
  localparam int M  = N / CC;
  localparam int OW = clog2(N) + 1;
  localparam int PW = pc_width(M);
  localparam int CW = (CC > 1) ? clog2(CC) : 1;
  localparam logic [OW-1:0] THR_W = OW'(THR);
  localparam logic [CW-1:0] LAST  = CW'(CC - 1);

  generate
    if (N % CC != 0) begin : g_bad_ratio
      $error("hamming_thresh_nbit_ncc: N must be a multiple of CC");
    end
    if ($bits(bus.g_input) != M) begin : g_bad_if
      $error("hamming_thresh_nbit_ncc: interface N/CC differ from module");
    end
  endgenerate

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [OW-1:0] o_reg, o_next;
  logic          match_reg, match_next;
  logic          done_reg, done_next;
  logic [PW-1:0] pc;
  logic [OW-1:0] sum;

  popcount_mbit #(.M(M)) u_popcount (
    .in_bits (bus.g_input ^ bus.e_input),
    .count   (pc)
  );

  assign sum = o_reg + OW'(pc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      o_reg     <= '0;
      match_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      o_reg     <= o_next;
      match_reg <= match_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    o_next     = o_reg;
    match_next = match_reg;
    done_next  = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (bus.start) begin
          // Chunk 0 replaces the previous result outright.
          o_next   = OW'(pc);
          cnt_next = CW'(1);
          if (CC == 1) begin
            done_next  = 1'b1;
            match_next = (OW'(pc) <= THR_W);
          end else begin
            state_next = ACC;
          end
        end
      end
      ACC: begin
        // Inputs are consumed every cycle here; start is ignored.
        o_next   = sum;
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == LAST) begin
          done_next  = 1'b1;
          match_next = (sum <= THR_W);
          cnt_next   = '0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.o     = o_reg;
  assign bus.match = match_reg;
  assign bus.done  = done_reg;
  assign bus.busy  = (state_reg == ACC);
endmodule

// File: doc/hamming_thresh_nbit_ncc.md
# hamming_thresh_nbit_ncc

Sequential Hamming-distance engine for garbled-circuit benchmarks: two N-bit vectors (garbler and evaluator) stream in over CC cycles, M = N/CC bits per cycle. The block accumulates the distance, flags completion, and compares the result against a fixed threshold for match/no-match decisions such as biometric matching. It adds a start/done handshake and back-to-back vector processing without a reset between vectors.

## Interface
- N, 32: total bits per vector.
- CC, 8: cycles per vector; N % CC == 0 is required and checked at elaboration.
- M, N/CC: bits per cycle (derived, not overridden).
- THR, N/4: match threshold, inclusive.
- OW, log2(N)+1: output width, so the value N is representable (log2 is the ceiling log2 from the common header).
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  starts a vector; chunk 0 is presented in the same cycle.
- g_input  in  M  garbler chunk.
- e_input  in  M  evaluator chunk.
- o  out  OW  accumulated distance; final only while/after done.
- match  out  1  (final distance <= THR); valid with done.
- done  out  1  one-cycle pulse when the final distance is in o.
- busy  out  1  high while chunks 1..CC-1 are expected.

## Operation
- Chunk k is vector bits [k*M +: M], LSB chunk first.
- Per cycle, contribution = popcount(g_input ^ e_input), range 0..M. The accumulator is OW bits wide and never overflows.
- FSM states: IDLE, ACC.
- **IDLE**
  - start=1: o <= popcount(chunk 0), cnt <= 1.
  - If CC==1: set done, match, and stay in IDLE.
  - Otherwise: go to ACC, busy=1.
  - start=0: hold o and match, done=0.
- **ACC**
  - Each cycle: o <= o + popcount, cnt++.
  - When cnt == CC-1, the sampled chunk is the last one. Then:
    - o takes its final value.
    - done <= 1 for one cycle.
    - match <= (final <= THR).
    - Return to IDLE, busy=0.
- start in ACC is ignored; inputs are consumed unconditionally every ACC cycle.
- o shows the running partial sum while busy. Outside that window, o and match hold their last final values until the next accepted start.
- Reset, including mid-vector: o=0, match=0, done=0, busy=0, cnt=0, state IDLE. The partial vector is discarded.

## Timing
- Start accepted at edge e0. Chunk k is sampled at edge e0+k.
- done is high in the cycle after edge e0+CC-1, which is CC cycles after the start cycle.
- Zero bubble: start may be asserted in the done cycle. That cycle's inputs are chunk 0 of the next vector. done drops, and o is overwritten at that edge.
- CC==1: start every cycle gives a done and a fresh o every cycle.
- All outputs are registered; there is no combinational input-to-output path.

## Structure
- Package hamming_pkg holds:
  - the state typedef (IDLE, ACC);
  - a width helper for the popcount output, log2(M)+1.
- Sub-module popcount_mbit:
  - combinational adder tree, M-bit input, log2(M)+1-bit output;
  - reused by the other Hamming variants.
- Top contains the FSM, the cycle counter (width log2(CC), minimum 1), the accumulator, and the compare.

## Test plan
- N=8, CC=8, THR=2; G=A9, E=7B streamed LSB first from a start -> done 8 cycles after start, o=4, match=0, done high exactly one cycle.
- Same configuration, back-to-back: G=74/E=9D, with start asserted in the done cycle, then G=AA/E=AA -> o=5, match=0, then o=0, match=1. No idle cycle between vectors.
- N=32, CC=4, THR=8; G=FFFFFFFF, E=00000000 -> o=32 (6-bit output), match=0, done 4 cycles after start. Then G=0000000F, E=00000000 -> o=4, match=1.
- Reset mid-vector: N=8, CC=8; assert rst asynchronously after 3 chunks -> o=0, busy=0, done=0 immediately. After release, G=A9/E=7B -> o=4 with no residue from the aborted vector.
- start pulsed during ACC with arbitrary data -> ignored; result and done timing are unchanged from the undisturbed run.
- N=8, CC=1, THR=4; start held high with G=0F/E=F0, then G=01/E=00 -> done every cycle; o=8, match=0, then o=1, match=1.
